// File: rtl/sync_fifo_prog.sv
// Synchronous single-clock FIFO with programmable almost-full / almost-empty
// levels, sticky overflow/underflow flags, synchronous flush and a choice of
// registered-read or first-word-fall-through read presentation.
//
// Handshake semantics (both sides are request/accept, there is no stall):
//   write side: a word on wr_data_i is taken at the rising edge where
//     wr_en_i=1 and the FIFO is not full, or is full but a read is accepted
//     in the same edge. A refused write sets overflow_o.
//   read side:  a read is accepted at the rising edge where rd_en_i=1 and the
//     FIFO is not empty. A read request against an empty FIFO sets
//     underflow_o. With FWFT=0 the popped word appears on rd_data_o one cycle
//     later, qualified by a single-cycle rd_data_valid_o pulse. With FWFT=1
//     the head word is always presented with rd_data_valid_o=!empty_o, and
//     rd_en_i acts as the pop acknowledge.
//   flush_i and rst_n override both sides for the cycle they are asserted.
module sync_fifo_prog #(
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_DEPTH    = 8,
  parameter int CNT_WIDTH     = $clog2(DATA_DEPTH),
  parameter int AFULL_THRESH  = DATA_DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter bit FWFT          = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_data_valid_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o,
  output logic [CNT_WIDTH:0]    elem_cnt_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  // Thresholds and depth sized to the count register so every level compare
  // is a same-width unsigned compare.
  localparam logic [CNT_WIDTH:0] DEPTH_C  = (CNT_WIDTH + 1)'(DATA_DEPTH);
  localparam logic [CNT_WIDTH:0] AFULL_C  = (CNT_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [CNT_WIDTH:0] AEMPTY_C = (CNT_WIDTH + 1)'(AEMPTY_THRESH);
  localparam logic [CNT_WIDTH:0] ONE_C    = (CNT_WIDTH + 1)'(1);
  localparam logic [CNT_WIDTH-1:0] PTR_ONE_C = CNT_WIDTH'(1);

  // Storage is deliberately not reset; the count decides what is valid.
  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic [CNT_WIDTH-1:0] wr_ptr_q;
  logic [CNT_WIDTH-1:0] rd_ptr_q;
  logic [CNT_WIDTH:0]   cnt_q;
  logic                 overflow_q;
  logic                 underflow_q;

  logic                 req_en;
  logic                 rd_ok;
  logic                 wr_ok;
  logic                 wr_rej;
  logic                 rd_rej;

  // Level flags all come straight from the registered count.
  always_comb begin
    empty_o        = (cnt_q == '0);
    full_o         = (cnt_q == DEPTH_C);
    almost_full_o  = (cnt_q >= AFULL_C);
    almost_empty_o = (cnt_q <= AEMPTY_C);
    elem_cnt_o     = cnt_q;
    overflow_o     = overflow_q;
    underflow_o    = underflow_q;
  end

  // Accept decisions; reset and flush mask all requests in their cycle.
  always_comb begin
    req_en = rst_n && !flush_i;
    rd_ok  = req_en && rd_en_i && !empty_o;
    // A full FIFO still takes a write when a read frees a slot this edge.
    wr_ok  = req_en && wr_en_i && (!full_o || rd_ok);
    wr_rej = wr_en_i && !(!full_o || rd_ok);
    rd_rej = rd_en_i && empty_o;
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  // Write and read pointers; both wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE_C;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE_C;
    end
  end

  // Entry count: a simultaneous accepted read and write cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + ONE_C;
        2'b01:   cnt_q <= cnt_q - ONE_C;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset or flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_rej) overflow_q  <= 1'b1;
      if (rd_rej) underflow_q <= 1'b1;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word presented combinationally; forced to zero while empty so
      // nothing stale from storage ever reaches the output.
      always_comb begin
        rd_data_valid_o = !empty_o;
        rd_data_o       = empty_o ? '0 : mem[rd_ptr_q];
      end
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      // Registered read: popped word appears one cycle after acceptance and
      // holds until the next accepted read.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (flush_i) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_ok;
          if (rd_ok) rd_data_q <= mem[rd_ptr_q];
        end
      end

      // Drive the registered read port.
      always_comb begin
        rd_data_o       = rd_data_q;
        rd_data_valid_o = rd_valid_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: one registered-read instance and one FWFT
// instance share the same stimulus. A queue-based reference model tracks the
// FIFO contents; popped words are pushed to an expected queue that a negedge
// monitor drains whenever the registered-read instance flags valid data.
module tb_sync_fifo_prog;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 3;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     = 1'b0;
  logic          flush_i   = 1'b0;
  logic          wr_en_i   = 1'b0;
  logic [DW-1:0] wr_data_i = '0;
  logic          rd_en_i   = 1'b0;

  logic [DW-1:0] d0_data, d1_data;
  logic          d0_valid, d1_valid;
  logic          d0_empty, d0_full, d0_aempty, d0_afull, d0_ovf, d0_unf;
  logic          d1_empty, d1_full, d1_aempty, d1_afull, d1_ovf, d1_unf;
  logic [CW:0]   d0_cnt, d1_cnt;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
    .rd_data_o(d0_data), .rd_data_valid_o(d0_valid),
    .empty_o(d0_empty), .full_o(d0_full),
    .almost_empty_o(d0_aempty), .almost_full_o(d0_afull),
    .elem_cnt_o(d0_cnt), .overflow_o(d0_ovf), .underflow_o(d0_unf)
  );

  sync_fifo_prog #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
    .rd_data_o(d1_data), .rd_data_valid_o(d1_valid),
    .empty_o(d1_empty), .full_o(d1_full),
    .almost_empty_o(d1_aempty), .almost_full_o(d1_afull),
    .elem_cnt_o(d1_cnt), .overflow_o(d1_ovf), .underflow_o(d1_unf)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] model_q[$];   // words currently stored, head at index 0
  logic [DW-1:0] exp_q[$];     // words expected on the registered read port
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  logic [DW-1:0] m_last0 = '0; // value the registered port should hold
  bit            mon_en = 1'b0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Applies the FIFO rules to the inputs sampled at the edge just taken.
  task automatic model_apply();
    bit rd_ok, wr_ok;
    logic [DW-1:0] v;
    if (!rst_n) begin
      model_q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_last0 = '0;
    end else if (flush_i) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd_ok = rd_en_i && (model_q.size() != 0);
      wr_ok = wr_en_i && ((model_q.size() != DEPTH) || rd_ok);
      if (rd_en_i && model_q.size() == 0) m_unf = 1'b1;
      if (wr_en_i && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) begin
        v = model_q.pop_front();
        exp_q.push_back(v);
        m_last0 = v;
      end
      if (wr_ok) model_q.push_back(wr_data_i);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit f, input bit w, input logic [DW-1:0] d, input bit rd);
    rst_n     = r;
    flush_i   = f;
    wr_en_i   = w;
    wr_data_i = d;
    rd_en_i   = rd;
    @(posedge clk);
    model_apply();
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int sz;
    logic [DW-1:0] e;
    if (mon_en) begin
      sz = model_q.size();
      chk("cnt0",    64'(d0_cnt),    64'(sz));
      chk("empty0",  64'(d0_empty),  64'(sz == 0));
      chk("full0",   64'(d0_full),   64'(sz == DEPTH));
      chk("afull0",  64'(d0_afull),  64'(sz >= AF));
      chk("aempty0", 64'(d0_aempty), 64'(sz <= AE));
      chk("ovf0",    64'(d0_ovf),    64'(m_ovf));
      chk("unf0",    64'(d0_unf),    64'(m_unf));
      chk("cnt1",    64'(d1_cnt),    64'(sz));
      chk("empty1",  64'(d1_empty),  64'(sz == 0));
      chk("full1",   64'(d1_full),   64'(sz == DEPTH));
      chk("afull1",  64'(d1_afull),  64'(sz >= AF));
      chk("aempty1", 64'(d1_aempty), 64'(sz <= AE));
      chk("ovf1",    64'(d1_ovf),    64'(m_ovf));
      chk("unf1",    64'(d1_unf),    64'(m_unf));
      // Registered read port: every valid pulse consumes one expected word.
      if (d0_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd0_spurious_valid", 64'(d0_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rd0_data", 64'(d0_data), 64'(e));
        end
      end
      chk("rd0_pending", 64'(exp_q.size()), 64'(0));
      chk("rd0_hold", 64'(d0_data), 64'(m_last0));
      // FWFT port: head of the stored contents, valid whenever non-empty.
      chk("fwft_valid", 64'(d1_valid), 64'(sz != 0));
      if (sz != 0) chk("fwft_data", 64'(d1_data), 64'(model_q[0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wp, rp;
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hdead, 1'b1);
    mon_en = 1'b1;
    idle();

    // Fill with 1..8, then one write too many.
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 1'b1, DW'(i), 1'b0);
    idle();
    // Drain all eight, then one read too many.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle();
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Full FIFO with simultaneous write and read of 0xA5.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, DW'($urandom), 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hA5, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle();

    // Empty FIFO with simultaneous write and read: only the write lands.
    step(1'b1, 1'b0, 1'b1, 32'h77, 1'b1);
    idle();
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle();
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Fall-through presentation of a single word, then pop it.
    step(1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
    idle();
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle();

    // Pointer wrap, then flush with three stored, then a fresh word.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b1, DW'($urandom), 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, DW'($urandom), 1'b0);
    step(1'b1, 1'b0, 1'b1, '0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h5555, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'hBEEF, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle();

    // Reset in the middle of traffic, with requests still asserted.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, DW'($urandom), 1'b0);
    step(1'b1, 1'b0, 1'b1, DW'($urandom), 1'b1);
    step(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1);
    idle();

    // Random traffic with alternating fill-heavy and drain-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      wp = ((i / 250) % 2 == 0) ? 70 : 35;
      rp = 100 - wp;
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < wp),
           DW'($urandom),
           ($urandom_range(0, 99) < rp));
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one data word.
REQ-002 SHALL have parameter DATA_DEPTH, default 8, number of entries; power of two, minimum 2.
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(DATA_DEPTH), pointer width.
REQ-004 SHALL have parameter AFULL_THRESH, default DATA_DEPTH-2, almost-full level, range 1..DATA_DEPTH.
REQ-005 SHALL have parameter AEMPTY_THRESH, default 1, almost-empty level, range 0..DATA_DEPTH-1.
REQ-006 SHALL have parameter FWFT, default 0; 0 = standard registered read, 1 = first-word-fall-through.
REQ-007 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-009 SHALL have port flush_i  input  1  synchronous clear of contents and sticky flags.
REQ-010 SHALL have port wr_en_i  input  1  write request.
REQ-011 SHALL have port wr_data_i  input  DATA_WIDTH  write data.
REQ-012 SHALL have port rd_en_i  input  1  read request (FWFT=1: pop acknowledge).
REQ-013 SHALL have port rd_data_o  output  DATA_WIDTH  read data.
REQ-014 SHALL have port rd_data_valid_o  output  1  rd_data_o qualifier.
REQ-015 SHALL have ports empty_o, full_o, almost_empty_o, almost_full_o  output  1 each  level flags.
REQ-016 SHALL have port elem_cnt_o  output  CNT_WIDTH+1  stored entry count, registered.
REQ-017 SHALL have ports overflow_o, underflow_o  output  1 each  sticky error flags.

Function
REQ-018 SHALL derive empty_o = (elem_cnt_o == 0), full_o = (elem_cnt_o == DATA_DEPTH), almost_full_o = (elem_cnt_o >= AFULL_THRESH), almost_empty_o = (elem_cnt_o <= AEMPTY_THRESH), all combinational from registered count.
REQ-019 SHALL accept a read (rd_ok) when rd_en_i=1 and empty_o=0.
REQ-020 SHALL accept a write (wr_ok) when wr_en_i=1 and (full_o=0 or rd_ok=1); write-while-full with simultaneous read is accepted.
REQ-021 SHALL reject a write when empty-with-no-read rules do not apply; a simultaneous read and write while empty accepts only the write.
REQ-022 SHALL update elem_cnt_o: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
REQ-023 SHALL store data at wr_ptr and advance wr_ptr on wr_ok; advance rd_ptr on rd_ok; both pointers wrap modulo DATA_DEPTH.
REQ-024 SHALL, with FWFT=0, register ram[rd_ptr] into rd_data_o one cycle after rd_ok with rd_data_valid_o=1 for that single cycle; rd_data_o holds its last value otherwise.
REQ-025 SHALL, with FWFT=1, drive rd_data_o = ram[rd_ptr] and rd_data_valid_o = !empty_o combinationally; rd_ok pops the head in the same cycle.
REQ-026 SHALL set overflow_o on wr_en_i=1 with the write rejected, and underflow_o on rd_en_i=1 with empty_o=1; both remain set until reset or flush.
REQ-027 SHALL, on flush_i=1, clear pointers, elem_cnt_o, overflow_o, underflow_o and rd_data_valid_o next cycle; flush overrides wr_en_i/rd_en_i that cycle; rd_data_o retains its value.
REQ-028 SHALL keep a write accepted in the cycle immediately after flush independent of pre-flush contents.

Reset
REQ-029 SHALL, when rst_n=0 at a rising edge, set wr_ptr, rd_ptr, elem_cnt_o to 0, rd_data_o to 0, rd_data_valid_o, overflow_o, underflow_o to 0; empty_o=1, almost_empty_o=1, full_o=0.
REQ-030 SHALL NOT reset storage array contents; reset mid-operation discards all entries, and no output depends on stale storage.
REQ-031 SHALL give reset priority over flush_i and all requests.

Verification (DATA_DEPTH=8, DATA_WIDTH=32, defaults unless stated)
REQ-032 Write 8 words 0x1..0x8 -> full_o=1 after 8th, almost_full_o=1 from count 6; 9th write -> overflow_o=1, count stays 8.
REQ-033 FWFT=0: read 8 times -> rd_data_o 0x1..0x8 each one cycle after rd_en_i with rd_data_valid_o=1; then empty_o=1; extra read -> underflow_o=1.
REQ-034 Full FIFO, wr_en_i=rd_en_i=1 with wr_data_i=0xA5 -> count stays 8, no overflow, 0xA5 read out last after 8 pops.
REQ-035 Empty FIFO, wr_en_i=rd_en_i=1 -> count 1, underflow_o=1, no rd_data_valid_o pulse.
REQ-036 FWFT=1: write 0x11 -> next cycle rd_data_o=0x11, rd_data_valid_o=1; pop -> valid drops to 0 next cycle.
REQ-037 20 write/read pairs (pointer wrap), then flush_i with 3 stored -> count 0, flags cleared, next data read equals first post-flush write; rst_n low mid-stream -> all outputs per REQ-029.
